sha3_state_drain: RTL and testbench



---
 rtl/sha3_pkg.sv | 11 +
 rtl/sha3_state_slot.sv | 21 ++
 rtl/sha3_state_drain.sv | 94 +++++++++
 tb/tb_sha3_state_drain.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared Keccak state types, sizes and lane ordering helper
package sha3_pkg;
    localparam int LANE_W = 64;
    localparam int LANES  = 25;
    localparam int ROWS   = 5;
    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t state_t [ROWS][ROWS];
    function automatic logic [4:0] lane_index(input int row, input int col);
        return 5'(row * ROWS + col);
    endfunction
endpackage

// File: rtl/sha3_state_slot.sv
// sha3_state_slot: one registered 25-lane state slot with a lane-select read port
// clk: clock; we: capture wdata; wdata: full state; sel: lane index 0..24; rdata: selected lane
module sha3_state_slot
    import sha3_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  state_t     wdata,
    input  logic [4:0] sel,
    output lane_t      rdata
);
    state_t q;
    always_ff @(posedge clk)
        if (we) q <= wdata;
    always_comb begin
        rdata = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < ROWS; c++)
                if (lane_index(r, c) == sel) rdata = q[r][c];
    end
endmodule

// File: rtl/sha3_state_drain.sv
// sha3_state_drain: captures full 1600-bit states on sample and streams them out lane by lane
// clk/rstn: clock, async active-low reset; isa..ise: row lanes; sample: capture strobe
// odata/olane/olast/ovalid/iready: lane stream handshake; busy: a slot is occupied; overflow: strobe dropped
module sha3_state_drain
    import sha3_pkg::*;
#(
    parameter int BUFFERS = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] isa [5],
    input  logic [63:0] isb [5],
    input  logic [63:0] isc [5],
    input  logic [63:0] isd [5],
    input  logic [63:0] ise [5],
    input  logic        sample,
    output logic [63:0] odata,
    output logic [4:0]  olane,
    output logic        olast,
    output logic        ovalid,
    input  logic        iready,
    output logic        busy,
    output logic        overflow
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    logic [0:0] st;
    logic [1:0] occ, occ_n;
    logic       wp, rp, rp_n;
    logic [4:0] beat, beat_n;
    logic       acc, rel, free, cap, go;
    lane_t      rd [2];
    lane_t      odata_n;
    state_t     ws;
    always_comb begin
        ws[0] = isa;
        ws[1] = isb;
        ws[2] = isc;
        ws[3] = isd;
        ws[4] = ise;
    end
    assign acc    = ovalid && iready;
    assign rel    = acc && beat == 5'(LANES - 1);
    // releasing the head slot frees it for a strobe on the same edge
    assign free   = occ < 2'(BUFFERS) || rel;
    assign cap    = sample && free;
    assign occ_n  = occ + 2'(cap) - 2'(rel);
    assign rp_n   = rel ? (BUFFERS == 2 ? ~rp : 1'b0) : rp;
    assign beat_n = (st == IDLE || rel) ? 5'd0 : acc ? beat + 5'd1 : beat;
    assign go     = (st == IDLE) ? occ != 2'd0 : (!rel || occ_n != 2'd0);
    // the next head may be the slot written on this very edge, so take lane 0 straight from the inputs
    assign odata_n = (cap && wp == rp_n) ? isa[0] : rd[rp_n];
    for (genvar i = 0; i < BUFFERS; i++) begin : g_slot
        sha3_state_slot u_slot (
            .clk   (clk),
            .we    (cap && wp == 1'(i)),
            .wdata (ws),
            .sel   (beat_n),
            .rdata (rd[i])
        );
    end
    if (BUFFERS == 1) begin : g_pad
        assign rd[1] = '0;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= IDLE;
            occ      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            beat     <= '0;
            odata    <= '0;
            olane    <= '0;
            olast    <= 1'b0;
            ovalid   <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            st       <= go ? STREAM : IDLE;
            occ      <= occ_n;
            if (cap) wp <= BUFFERS == 2 ? ~wp : 1'b0;
            rp       <= rp_n;
            beat     <= beat_n;
            ovalid   <= go;
            olast    <= go && beat_n == 5'(LANES - 1);
            busy     <= occ_n != 2'd0;
            overflow <= sample && !free;
            if (go) begin
                odata <= odata_n;
                olane <= beat_n;
            end
        end
    end
endmodule

// File: tb/tb_sha3_state_drain.sv
// tb_sha3_state_drain: directed self-checking bench for sha3_state_drain (BUFFERS=2 and BUFFERS=1)
module tb_sha3_state_drain;
    logic        clk, rstn, sample, iready;
    logic [63:0] isa [5], isb [5], isc [5], isd [5], ise [5];
    logic [63:0] o2d, o1d;
    logic [4:0]  o2l, o1l;
    logic        o2last, o1last, o2v, o1v, b2, b1, ov2, ov1;
    int          n_cmp, n_err, e;

    sha3_state_drain #(.BUFFERS(2)) u2 (
        .clk(clk), .rstn(rstn), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample), .odata(o2d), .olane(o2l), .olast(o2last), .ovalid(o2v),
        .iready(iready), .busy(b2), .overflow(ov2)
    );
    sha3_state_drain #(.BUFFERS(1)) u1 (
        .clk(clk), .rstn(rstn), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample), .odata(o1d), .olane(o1l), .olast(o1last), .ovalid(o1v),
        .iready(iready), .busy(b1), .overflow(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] base);
        for (int c = 0; c < 5; c++) begin
            isa[c] = base | 64'(0 * 5 + c);
            isb[c] = base | 64'(1 * 5 + c);
            isc[c] = base | 64'(2 * 5 + c);
            isd[c] = base | 64'(3 * 5 + c);
            ise[c] = base | 64'(4 * 5 + c);
        end
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        sample = 1'b0;
        iready = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
    endtask

    task automatic beat(input int u, input logic [63:0] base, input int k);
        chk($sformatf("u%0d valid k%0d", u, k), u == 1 ? o1v : o2v, 1);
        chk($sformatf("u%0d lane k%0d", u, k), u == 1 ? o1l : o2l, 64'(k));
        chk($sformatf("u%0d data k%0d", u, k), u == 1 ? o1d : o2d, base | 64'(k));
        chk($sformatf("u%0d last k%0d", u, k), u == 1 ? o1last : o2last, 64'(k == 24));
        tick;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0;
        sample = 1'b0;
        iready = 1'b0;
        load(64'h0);
        tick;
        tick;
        chk("rst ovalid", o2v, 0);
        chk("rst odata", o2d, 0);
        chk("rst olane", o2l, 0);
        chk("rst olast", o2last, 0);
        chk("rst busy", b2, 0);
        chk("rst overflow", ov2, 0);
        chk("rst u1 ovalid", o1v, 0);
        rstn = 1'b1;
        tick;

        // single state, iready held high
        load(64'hA5A5_0000_0000_0000);
        iready = 1'b1;
        sample = 1'b1;
        tick;
        sample = 1'b0;
        chk("single lat ovalid", o2v, 0);
        chk("single busy", b2, 1);
        tick;
        for (int k = 0; k < 25; k++) beat(2, 64'hA5A5_0000_0000_0000, k);
        chk("single idle ovalid", o2v, 0);
        chk("single idle busy", b2, 0);

        // backpressure: iready pattern 1,0,0,1
        do_reset;
        load(64'hA5A5_0000_0000_0000);
        sample = 1'b1;
        tick;
        sample = 1'b0;
        tick;
        e = 0;
        for (int cyc = 0; cyc < 200 && e < 25; cyc++) begin
            chk($sformatf("bp valid c%0d", cyc), o2v, 1);
            chk($sformatf("bp lane c%0d", cyc), o2l, 64'(e));
            chk($sformatf("bp data c%0d", cyc), o2d, 64'hA5A5_0000_0000_0000 | 64'(e));
            iready = (cyc % 4 == 1 || cyc % 4 == 2) ? 1'b0 : 1'b1;
            tick;
            if (iready) e++;
        end
        chk("bp accepted", 64'(e), 25);
        chk("bp idle ovalid", o2v, 0);

        // back-to-back strobes stream 50 beats with no bubble
        do_reset;
        iready = 1'b1;
        load(64'h0);
        sample = 1'b1;
        tick;
        load(64'h40);
        tick;
        sample = 1'b0;
        for (int k = 0; k < 50; k++) begin
            chk($sformatf("b2b overflow k%0d", k), ov2, 0);
            beat(2, k < 25 ? 64'h0 : 64'h40, k % 25);
        end
        chk("b2b idle ovalid", o2v, 0);

        // overflow: three strobes while stalled
        do_reset;
        load(64'h0);
        sample = 1'b1;
        tick;
        chk("ovf after s0", ov2, 0);
        load(64'h40);
        tick;
        chk("ovf after s1", ov2, 0);
        load(64'h80);
        tick;
        sample = 1'b0;
        chk("ovf pulse", ov2, 1);
        tick;
        chk("ovf pulse end", ov2, 0);
        iready = 1'b1;
        for (int k = 0; k < 50; k++) beat(2, k < 25 ? 64'h0 : 64'h40, k % 25);
        chk("ovf idle ovalid", o2v, 0);

        // BUFFERS=1: drop mid-stream, capture on coincident lane-24 accept
        do_reset;
        iready = 1'b1;
        load(64'h0);
        sample = 1'b1;
        tick;
        sample = 1'b0;
        tick;
        for (int k = 0; k < 25; k++) begin
            if (k == 10 || k == 24) begin
                load(k == 10 ? 64'h80 : 64'h40);
                sample = 1'b1;
            end
            beat(1, 64'h0, k);
            sample = 1'b0;
            if (k == 10) chk("b1 drop overflow", ov1, 1);
            if (k == 24) chk("b1 coincident overflow", ov1, 0);
        end
        for (int k = 0; k < 25; k++) beat(1, 64'h40, k);
        chk("b1 idle ovalid", o1v, 0);

        // reset mid-stream
        do_reset;
        iready = 1'b1;
        load(64'h0);
        sample = 1'b1;
        tick;
        sample = 1'b0;
        tick;
        for (int k = 0; k < 10; k++) beat(2, 64'h0, k);
        chk("mid lane10", o2l, 10);
        rstn = 1'b0;
        #1;
        chk("mid rst ovalid", o2v, 0);
        chk("mid rst olane", o2l, 0);
        chk("mid rst busy", b2, 0);
        tick;
        rstn = 1'b1;
        load(64'h40);
        sample = 1'b1;
        tick;
        sample = 1'b0;
        tick;
        for (int k = 0; k < 25; k++) beat(2, 64'h40, k);
        chk("mid idle ovalid", o2v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
